rf_ex_pipe_reg: RTL and testbench



---
 rtl/rf_ex_pipe_reg.sv | 131 +++++++++++++
 tb/tb_rf_ex_pipe_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_ex_pipe_reg.sv
// rtl/rf_ex_pipe_reg.sv - RF/EX pipeline register with valid, stall, flush and bubble counter
module rf_ex_pipe_reg #(
    parameter int DATA_W    = 64,
    parameter int SHAMT_W   = 6,
    parameter int ALUCTRL_W = 3,
    parameter int RADDR_W   = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_d,
    input  logic [DATA_W-1:0]    data_a_d,
    input  logic [DATA_W-1:0]    data_b_d,
    input  logic [DATA_W-1:0]    reg_b_out_stur_d,
    input  logic [SHAMT_W-1:0]   shamt_d,
    input  logic [ALUCTRL_W-1:0] aluControl_d,
    input  logic [RADDR_W-1:0]   reg_write_addr_d,
    input  logic                 MemRead_d,
    input  logic                 aluOrShift_d,
    input  logic                 MemtoReg_d,
    input  logic                 MemWrite_d,
    input  logic                 RegWrite_d,
    input  logic                 set_flags_d,
    output logic                 valid_q,
    output logic [DATA_W-1:0]    data_a_q,
    output logic [DATA_W-1:0]    data_b_q,
    output logic [DATA_W-1:0]    reg_b_out_stur_q,
    output logic [SHAMT_W-1:0]   shamt_q,
    output logic [ALUCTRL_W-1:0] aluControl_q,
    output logic [RADDR_W-1:0]   reg_write_addr_q,
    output logic                 MemRead_q,
    output logic                 aluOrShift_q,
    output logic                 MemtoReg_q,
    output logic                 MemWrite_q,
    output logic                 RegWrite_q,
    output logic                 set_flags_q,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 r_valid;
    logic [DATA_W-1:0]    r_data_a;
    logic [DATA_W-1:0]    r_data_b;
    logic [DATA_W-1:0]    r_stur;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [ALUCTRL_W-1:0] r_alu;
    logic [RADDR_W-1:0]   r_addr;
    logic                 r_mem_read;
    logic                 r_alu_or_shift;
    logic                 r_mem_to_reg;
    logic                 r_mem_write;
    logic                 r_reg_write;
    logic                 r_set_flags;
    logic [CNT_W-1:0]     r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_data_a       <= '0;
            r_data_b       <= '0;
            r_stur         <= '0;
            r_shamt        <= '0;
            r_alu          <= '0;
            r_addr         <= '0;
            r_mem_read     <= 1'b0;
            r_alu_or_shift <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_set_flags    <= 1'b0;
        end else if (flush) begin
            r_valid        <= 1'b0;
            r_data_a       <= '0;
            r_data_b       <= '0;
            r_stur         <= '0;
            r_shamt        <= '0;
            r_alu          <= '0;
            r_addr         <= '0;
            r_mem_read     <= 1'b0;
            r_alu_or_shift <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_set_flags    <= 1'b0;
        end else if (!stall) begin
            // Side-effect controls are gated so an invalid slot can never commit anything.
            r_valid        <= valid_d;
            r_data_a       <= data_a_d;
            r_data_b       <= data_b_d;
            r_stur         <= reg_b_out_stur_d;
            r_shamt        <= shamt_d;
            r_alu          <= aluControl_d;
            r_addr         <= reg_write_addr_d;
            r_mem_read     <= valid_d & MemRead_d;
            r_alu_or_shift <= aluOrShift_d;
            r_mem_to_reg   <= valid_d & MemtoReg_d;
            r_mem_write    <= valid_d & MemWrite_d;
            r_reg_write    <= valid_d & RegWrite_d;
            r_set_flags    <= valid_d & set_flags_d;
        end
    end

    // Counts every edge that sees an empty EX slot, stalled or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (!r_valid && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign valid_q          = r_valid;
    assign data_a_q         = r_data_a;
    assign data_b_q         = r_data_b;
    assign reg_b_out_stur_q = r_stur;
    assign shamt_q          = r_shamt;
    assign aluControl_q     = r_alu;
    assign reg_write_addr_q = r_addr;
    assign MemRead_q        = r_mem_read;
    assign aluOrShift_q     = r_alu_or_shift;
    assign MemtoReg_q       = r_mem_to_reg;
    assign MemWrite_q       = r_mem_write;
    assign RegWrite_q       = r_reg_write;
    assign set_flags_q      = r_set_flags;
    assign bubble_cnt       = r_bubble_cnt;

endmodule

// File: tb/tb_rf_ex_pipe_reg.sv
// tb/tb_rf_ex_pipe_reg.sv - self-checking bench for rf_ex_pipe_reg against a slot-level model
module tb_rf_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] st;
        logic [5:0]  shamt;
        logic [2:0]  alu;
        logic [4:0]  addr;
        logic        mr;
        logic        aos;
        logic        m2r;
        logic        mw;
        logic        rw;
        logic        sf;
    } slot_t;

    logic  clk = 1'b0;
    logic  reset, stall, flush;
    slot_t d;
    slot_t q, q4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    logic w_valid, w_mr, w_aos, w_m2r, w_mw, w_rw, w_sf;
    logic [63:0] w_a, w_b, w_st;
    logic [5:0] w_shamt;
    logic [2:0] w_alu;
    logic [4:0] w_addr;
    logic v_valid, v_mr, v_aos, v_m2r, v_mw, v_rw, v_sf;
    logic [63:0] v_a, v_b, v_st;
    logic [5:0] v_shamt;
    logic [2:0] v_alu;
    logic [4:0] v_addr;

    always #5 clk = ~clk;

    rf_ex_pipe_reg u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_d(d.valid), .data_a_d(d.a), .data_b_d(d.b), .reg_b_out_stur_d(d.st),
        .shamt_d(d.shamt), .aluControl_d(d.alu), .reg_write_addr_d(d.addr),
        .MemRead_d(d.mr), .aluOrShift_d(d.aos), .MemtoReg_d(d.m2r),
        .MemWrite_d(d.mw), .RegWrite_d(d.rw), .set_flags_d(d.sf),
        .valid_q(w_valid), .data_a_q(w_a), .data_b_q(w_b), .reg_b_out_stur_q(w_st),
        .shamt_q(w_shamt), .aluControl_q(w_alu), .reg_write_addr_q(w_addr),
        .MemRead_q(w_mr), .aluOrShift_q(w_aos), .MemtoReg_q(w_m2r),
        .MemWrite_q(w_mw), .RegWrite_q(w_rw), .set_flags_q(w_sf),
        .bubble_cnt(cnt16)
    );

    rf_ex_pipe_reg #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_d(d.valid), .data_a_d(d.a), .data_b_d(d.b), .reg_b_out_stur_d(d.st),
        .shamt_d(d.shamt), .aluControl_d(d.alu), .reg_write_addr_d(d.addr),
        .MemRead_d(d.mr), .aluOrShift_d(d.aos), .MemtoReg_d(d.m2r),
        .MemWrite_d(d.mw), .RegWrite_d(d.rw), .set_flags_d(d.sf),
        .valid_q(v_valid), .data_a_q(v_a), .data_b_q(v_b), .reg_b_out_stur_q(v_st),
        .shamt_q(v_shamt), .aluControl_q(v_alu), .reg_write_addr_q(v_addr),
        .MemRead_q(v_mr), .aluOrShift_q(v_aos), .MemtoReg_q(v_m2r),
        .MemWrite_q(v_mw), .RegWrite_q(v_rw), .set_flags_q(v_sf),
        .bubble_cnt(cnt4)
    );

    assign q  = {w_valid, w_a, w_b, w_st, w_shamt, w_alu, w_addr, w_mr, w_aos, w_m2r, w_mw, w_rw, w_sf};
    assign q4 = {v_valid, v_a, v_b, v_st, v_shamt, v_alu, v_addr, v_mr, v_aos, v_m2r, v_mw, v_rw, v_sf};

    int checks = 0;
    int errors = 0;
    slot_t m;
    int unsigned m_cnt16, m_cnt4;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_q", q.valid, m.valid);
        chk("data_a_q", q.a, m.a);
        chk("data_b_q", q.b, m.b);
        chk("stur_q", q.st, m.st);
        chk("shamt_q", q.shamt, m.shamt);
        chk("aluControl_q", q.alu, m.alu);
        chk("addr_q", q.addr, m.addr);
        chk("MemRead_q", q.mr, m.mr);
        chk("aluOrShift_q", q.aos, m.aos);
        chk("MemtoReg_q", q.m2r, m.m2r);
        chk("MemWrite_q", q.mw, m.mw);
        chk("RegWrite_q", q.rw, m.rw);
        chk("set_flags_q", q.sf, m.sf);
        chk("slot_cnt4", q4, m);
        chk("bubble_cnt16", cnt16, m_cnt16);
        chk("bubble_cnt4", cnt4, m_cnt4);
    endtask

    // One clock edge: inputs are already stable, model advances, outputs sampled 1 time unit later.
    task automatic step();
        logic was_empty;
        was_empty = !m.valid;
        @(posedge clk);
        if (flush) begin
            m = '0;
        end else if (!stall) begin
            m = d;
            if (!d.valid) begin
                m.mr = 1'b0; m.m2r = 1'b0; m.mw = 1'b0; m.rw = 1'b0; m.sf = 1'b0;
            end
        end
        if (was_empty) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m = '0;
        m_cnt16 = 0;
        m_cnt4 = 0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; d = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Scenario 1: plain load
        d.valid = 1'b1; d.a = 64'h0123_4567_89AB_CDEF; d.rw = 1'b1; d.addr = 5'd9; d.alu = 3'b010;
        step();
        chk("s1_data_a", q.a, 64'h0123_4567_89AB_CDEF);
        chk("s1_valid", q.valid, 1'b1);

        // Scenario 2: stall hold, then release
        stall = 1'b1; d.a = 64'hFFFF_FFFF_FFFF_FFFF; d.rw = 1'b0;
        repeat (3) begin
            step();
            chk("s2_hold_a", q.a, 64'h0123_4567_89AB_CDEF);
            chk("s2_hold_rw", q.rw, 1'b1);
        end
        stall = 1'b0;
        step();
        chk("s2_release_a", q.a, 64'hFFFF_FFFF_FFFF_FFFF);

        // Scenario 3: flush wins over stall
        d.mw = 1'b1;
        step();
        stall = 1'b1; flush = 1'b1;
        step();
        chk("s3_mw", q.mw, 1'b0);
        chk("s3_addr", q.addr, 5'd0);
        stall = 1'b0; flush = 1'b0;

        // Scenario 4: invalid gating
        d = '0; d.rw = 1'b1; d.mw = 1'b1; d.sf = 1'b1; d.b = 64'd42;
        step();
        chk("s4_data_b", q.b, 64'd42);

        // Scenario 5: async reset between edges
        d.valid = 1'b1;
        step();
        #2 reset = 1'b1;
        #2;
        model_reset();
        check_all();
        #1 reset = 1'b0;

        // Scenario 6: saturation of the narrow counter
        d = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("s6_cnt4", cnt4, (i > 15) ? 15 : i);
        end
        d.valid = 1'b1;
        step();
        step();
        chk("s6_cnt4_after_valid", cnt4, 4'd15);

        // Randomised traffic with occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            d.valid = ($urandom_range(0, 3) != 0);
            d.a = {$urandom, $urandom};
            d.b = {$urandom, $urandom};
            d.st = {$urandom, $urandom};
            d.shamt = 6'($urandom);
            d.alu = 3'($urandom);
            d.addr = 5'($urandom);
            d.mr = 1'($urandom); d.aos = 1'($urandom); d.m2r = 1'($urandom);
            d.mw = 1'($urandom); d.rw = 1'($urandom); d.sf = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step();
            if (i % 97 == 96) begin
                #1 reset = 1'b1;
                #1;
                model_reset();
                check_all();
                #1 reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
